sl_pipe: RTL and testbench

//  Pipelined logical left shifter: the left-shift counterpart to the combinational

---
 rtl/shift_pkg.sv | 16 +
 rtl/sl_stage.sv | 20 ++
 rtl/sl_pipe.sv | 113 +++++++++++
 tb/tb_sl_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined left shifter (sl_pipe).
// One barrel stage per pipeline register; stage k shifts by stage_amt(k).
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SHW-1:0]   shamt_t;

  // Stage 0 handles the largest power of two, the last stage shifts by one.
  function automatic int stage_amt(input int k);
    return 1 << (SHW - 1 - k);
  endfunction

endpackage

// File: rtl/sl_stage.sv
// One combinational barrel stage: shift (or rotate) left by SH when enabled.
module sl_stage
  import shift_pkg::*;
#(
  parameter int SH = 1
) (
  input  word_t data_i,
  input  logic  en_i,
  input  logic  rot_i,
  output word_t data_o
);

  word_t shifted;
  word_t wrapped;

  assign shifted = data_i << SH;
  assign wrapped = data_i >> (WIDTH - SH);
  assign data_o  = !en_i ? data_i : (rot_i ? (shifted | wrapped) : shifted);

endmodule

// File: rtl/sl_pipe.sv
// Pipelined logical left shifter with valid/ready on both ends, SHW stages.
// Optional feature: define SL_PIPE_ROTATE_EN to add in_rot (rotate instead of shift).
module sl_pipe
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
`ifdef SL_PIPE_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic   vld_q   [SHW];
  logic   vld_d   [SHW];
  word_t  data_q  [SHW];
  word_t  data_d  [SHW];
  shamt_t shamt_q [SHW];
  shamt_t shamt_d [SHW];
  logic   rot_q   [SHW];
  logic   rot_d   [SHW];

  logic   up_vld   [SHW];
  word_t  up_data  [SHW];
  shamt_t up_shamt [SHW];
  logic   up_rot   [SHW];
  word_t  stage_out[SHW];
  logic   rdy      [SHW+1];
  logic   rot_in;

`ifdef SL_PIPE_ROTATE_EN
  assign rot_in = in_rot;
`else
  assign rot_in = 1'b0;
`endif

  always_comb begin
    up_vld[0]   = in_valid;
    up_data[0]  = in_data;
    up_shamt[0] = in_shamt;
    up_rot[0]   = rot_in;
    for (int k = 1; k < SHW; k++) begin
      up_vld[k]   = vld_q[k-1];
      up_data[k]  = data_q[k-1];
      up_shamt[k] = shamt_q[k-1];
      up_rot[k]   = rot_q[k-1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    sl_stage #(.SH(stage_amt(k))) u_stage (
      .data_i (up_data[k]),
      .en_i   (up_shamt[k][SHW-1-k]),
      .rot_i  (up_rot[k]),
      .data_o (stage_out[k])
    );
  end

  // Ready ripples back combinationally so a full pipe still moves every cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    rdy[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
    for (int k = 0; k < SHW; k++) begin
      vld_d[k]   = vld_q[k];
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      rot_d[k]   = rot_q[k];
      if (rdy[k]) begin
        vld_d[k]   = up_vld[k];
        data_d[k]  = stage_out[k];
        shamt_d[k] = up_shamt[k];
        rot_d[k]   = up_rot[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    if (!resetn) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]   <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        rot_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]   <= vld_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        rot_q[k]   <= rot_d[k];
      end
    end
  end

  // Outputs are forced idle while reset is asserted, not only after the edge.
  assign in_ready  = resetn && rdy[0];
  assign out_valid = resetn && vld_q[SHW-1];
  assign out_data  = resetn ? data_q[SHW-1] : '0;

  logic tail_unused;
  assign tail_unused = ^{shamt_q[SHW-1], rot_q[SHW-1]};

endmodule

// File: tb/tb_sl_pipe.sv
// Self-checking bench for sl_pipe: directed vector table, corner sequences,
// and randomized traffic scored against a one-line shift/rotate model.
module tb_sl_pipe;
  import shift_pkg::*;

  logic   clk = 1'b0;
  logic   resetn;
  logic   in_valid;
  logic   in_ready;
  word_t  in_data;
  shamt_t in_shamt;
  logic   in_rot;
  logic   out_valid;
  logic   out_ready;
  word_t  out_data;

  always #5 clk = ~clk;

  sl_pipe dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
`ifdef SL_PIPE_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifndef SL_PIPE_ROTATE_EN
  logic rot_unused;
  assign rot_unused = in_rot;
`endif

  typedef struct {
    word_t exp;
    int    cyc;
    bit    strict;
  } exp_t;

  typedef struct {
    word_t  d;
    shamt_t s;
    logic   r;
    word_t  exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   strict = 1'b0;

  // Reference: rotate via a doubled word, shift via plain arithmetic.
  function automatic word_t model(input word_t d, input int s, input logic r);
    logic [2*WIDTH-1:0] w;
    w = {d, d} << s;
    if (r) return w[2*WIDTH-1:WIDTH];
    return d << s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle, score any output that fires, queue any input that fires.
  task automatic cycle(input logic v, input word_t d, input shamt_t s, input logic r,
                       input word_t exp, input logic ordy,
                       output logic in_fired, output logic out_fired);
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_rot    = r;
    out_ready = ordy;
    #1;
    in_fired  = v && (in_ready === 1'b1);
    out_fired = (out_valid === 1'b1) && ordy;
    if (out_fired) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(e.exp));
        if (e.strict) check("latency", 64'(cyc - e.cyc), 64'(SHW));
      end
    end
    if (in_fired) sb.push_back('{exp: exp, cyc: cyc, strict: strict});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name);
    logic fi, fo;
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, fi, fo);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fi, fo;
    int   acc;
    int   ghosts;

    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_rot = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_out_data", 64'(out_data), 64'd0);

    // Directed vectors, expected values hand-derived.
    vecs.push_back('{d: 32'h0000_0001, s: 5'd31, r: 1'b0, exp: 32'h8000_0000});
    vecs.push_back('{d: 32'hDEAD_BEEF, s: 5'd0,  r: 1'b0, exp: 32'hDEAD_BEEF});
    vecs.push_back('{d: 32'hC000_0003, s: 5'd2,  r: 1'b0, exp: 32'h0000_000C});
    vecs.push_back('{d: 32'hFFFF_FFFF, s: 5'd16, r: 1'b0, exp: 32'hFFFF_0000});
    vecs.push_back('{d: 32'h1234_5678, s: 5'd4,  r: 1'b0, exp: 32'h2345_6780});
    vecs.push_back('{d: 32'h8000_0001, s: 5'd1,  r: 1'b0, exp: 32'h0000_0002});
    vecs.push_back('{d: 32'hA5A5_A5A5, s: 5'd31, r: 1'b0, exp: 32'h8000_0000});
    vecs.push_back('{d: 32'hF0F0_F0F0, s: 5'd8,  r: 1'b0, exp: 32'hF0F0_F000});
`ifdef SL_PIPE_ROTATE_EN
    vecs.push_back('{d: 32'h8000_0001, s: 5'd1,  r: 1'b1, exp: 32'h0000_0003});
    vecs.push_back('{d: 32'hF000_0000, s: 5'd4,  r: 1'b1, exp: 32'h0000_000F});
    vecs.push_back('{d: 32'h0000_0003, s: 5'd31, r: 1'b1, exp: 32'h8000_0001});
`endif
    strict = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(1'b1, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].exp, 1'b1, fi, fo);
      check("vec_accept", 64'(fi), 64'd1);
    end
    drain("vec_drain");

    // Streaming: 8 back-to-back words, strict latency implies consecutive outputs.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h1, shamt_t'(i), 1'b0, word_t'(32'h1 << i), 1'b1, fi, fo);
      check("stream_accept", 64'(fi), 64'd1);
    end
    drain("stream_drain");

    // Backpressure: fill to SHW words, hold output, then in/out fire together.
    strict = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, word_t'(32'h100 + acc), shamt_t'(acc), 1'b0,
            word_t'((32'h100 + acc) << acc), 1'b0, fi, fo);
      if (fi) acc++;
      if (out_valid) check("bp_hold", 64'(out_data), 64'h100);
    end
    check("bp_accepted", 64'(acc), 64'(SHW));
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle(1'b1, word_t'(32'h100 + acc), shamt_t'(acc), 1'b0,
          word_t'((32'h100 + acc) << acc), 1'b1, fi, fo);
    check("bp_sixth_accept", 64'(fi), 64'd1);
    check("bp_out_same_cycle", 64'(fo), 64'd1);
    drain("bp_drain");

    // Reset with three words in flight: none may ever appear.
    strict = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFF_FFFF, shamt_t'(i), 1'b0, 32'h0, 1'b1, fi, fo);
    resetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    cyc++;
    resetn = 1'b1;
    sb.delete();
    #1;
    check("after_rst_in_ready", 64'(in_ready), 64'd1);
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    ghosts = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, fi, fo);
      if (out_valid !== 1'b0) ghosts++;
    end
    check("no_ghost_words", 64'(ghosts), 64'd0);

    // Random traffic, output always ready: value and exact latency.
    strict = 1'b1;
    for (int i = 0; i < 200; i++) begin
      word_t  d;
      shamt_t s;
      logic   r;
      d = $urandom;
      s = shamt_t'($urandom_range(WIDTH - 1, 0));
`ifdef SL_PIPE_ROTATE_EN
      r = 1'($urandom_range(1, 0));
`else
      r = 1'b0;
`endif
      cycle(($urandom_range(3, 0) != 0), d, s, r, model(d, int'(s), r), 1'b1, fi, fo);
    end
    drain("rand_a_drain");

    // Random traffic with random backpressure: value and order.
    strict = 1'b0;
    for (int i = 0; i < 300; i++) begin
      word_t  d;
      shamt_t s;
      logic   r;
      d = $urandom;
      s = shamt_t'($urandom_range(WIDTH - 1, 0));
`ifdef SL_PIPE_ROTATE_EN
      r = 1'($urandom_range(1, 0));
`else
      r = 1'b0;
`endif
      cycle(($urandom_range(3, 0) != 0), d, s, r, model(d, int'(s), r),
            ($urandom_range(3, 0) != 0), fi, fo);
    end
    drain("rand_b_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
